// File: rtl/div_seq.sv
// Multi-cycle 32-bit restoring divider (signed or unsigned) for the EX stage.
// It takes one quotient bit per clock. The result is {remainder, quotient}.
// An illegal-free FSM walks FREE -> ON/BYZERO -> END -> FREE.
module div_seq (
  input  logic        clk,
  input  logic        rst,
  input  logic        signed_div_i,
  input  logic [31:0] opdata1_i,
  input  logic [31:0] opdata2_i,
  input  logic        start_i,
  input  logic        annul_i,
  output logic [63:0] result_o,
  output logic        ready_o,
  output logic        busy_o
);

  localparam logic [1:0] S_FREE   = 2'd0;
  localparam logic [1:0] S_BYZERO = 2'd1;
  localparam logic [1:0] S_ON     = 2'd2;
  localparam logic [1:0] S_END    = 2'd3;

  logic [1:0]  r_state;
  logic [5:0]  r_cnt;
  logic [64:0] r_work;
  logic [31:0] r_dividend;
  logic [31:0] r_divisor;
  logic        r_neg_q;
  logic        r_neg_r;
  logic [63:0] r_result;
  logic        r_ready;
  logic        r_busy;

  logic        w_accept;
  logic        w_step_en;
  logic        w_neg1;
  logic        w_neg2;
  logic [33:0] w_rem_sh;
  logic [33:0] w_diff;
  logic        w_fits;
  logic [32:0] w_next_rem;
  logic [31:0] w_quot;
  logic [31:0] w_rem;

  // Two's-complement negation, applied only when en is set.
  function automatic logic [31:0] neg_if(input logic [31:0] v, input logic en);
    return en ? (~v + 32'd1) : v;
  endfunction

  assign w_accept  = (r_state == S_FREE) && start_i && !annul_i;
  assign w_step_en = (r_state == S_ON) && start_i && !annul_i && (r_cnt != 6'd32);
  assign w_neg1    = signed_div_i & opdata1_i[31];
  assign w_neg2    = signed_div_i & opdata2_i[31];

  // One restoring step: shift the next dividend bit into the partial remainder.
  // Then try to subtract the divisor. The partial remainder is always below
  // the divisor, so its upper bit stays clear between steps.
  assign w_rem_sh   = {r_work[64:32], r_dividend[31]};
  assign w_diff     = w_rem_sh - {2'b00, r_divisor};
  assign w_fits     = ~w_diff[33];
  assign w_next_rem = w_fits ? w_diff[32:0] : w_rem_sh[32:0];

  // Sign correction of the finished magnitudes.
  assign w_quot = neg_if(r_work[31:0], r_neg_q);
  assign w_rem  = neg_if(r_work[63:32], r_neg_r);

  // Operand magnitudes and sign flags: latched at accept, dividend shifts out MSB-first.
  always_ff @(posedge clk) begin
    if (w_accept) begin
      r_dividend <= neg_if(opdata1_i, w_neg1);
      r_divisor  <= neg_if(opdata2_i, w_neg2);
      r_neg_q    <= w_neg1 ^ w_neg2;
      r_neg_r    <= w_neg1;
    end else if (w_step_en) begin
      r_dividend <= {r_dividend[30:0], 1'b0};
    end
  end

  // Control FSM, step counter, working register and registered outputs.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      r_state  <= S_FREE;
      r_cnt    <= 6'd0;
      r_work   <= 65'd0;
      r_result <= 64'd0;
      r_ready  <= 1'b0;
      r_busy   <= 1'b0;
    end else begin
      case (r_state)
        S_FREE: begin
          r_ready  <= 1'b0;
          r_result <= 64'd0;
          if (w_accept) begin
            r_cnt   <= 6'd0;
            r_work  <= 65'd0;
            r_busy  <= 1'b1;
            r_state <= (opdata2_i == 32'd0) ? S_BYZERO : S_ON;
          end else begin
            r_busy <= 1'b0;
          end
        end
        S_BYZERO: begin
          r_busy   <= 1'b0;
          r_result <= 64'd0;
          if (annul_i || !start_i) begin
            r_ready <= 1'b0;
            r_state <= S_FREE;
          end else begin
            r_ready <= 1'b1;
            r_state <= S_END;
          end
        end
        S_ON: begin
          if (annul_i || !start_i) begin
            r_busy   <= 1'b0;
            r_ready  <= 1'b0;
            r_result <= 64'd0;
            r_state  <= S_FREE;
          end else if (r_cnt == 6'd32) begin
            r_busy   <= 1'b0;
            r_ready  <= 1'b1;
            r_result <= {w_rem, w_quot};
            r_state  <= S_END;
          end else begin
            r_work <= {w_next_rem, r_work[30:0], w_fits};
            r_cnt  <= r_cnt + 6'd1;
          end
        end
        S_END: begin
          r_busy <= 1'b0;
          if (annul_i || !start_i) begin
            r_ready  <= 1'b0;
            r_result <= 64'd0;
            r_state  <= S_FREE;
          end
        end
        default: begin
          r_busy   <= 1'b0;
          r_ready  <= 1'b0;
          r_result <= 64'd0;
          r_state  <= S_FREE;
        end
      endcase
    end
  end

  assign result_o = r_result;
  assign ready_o  = r_ready;
  assign busy_o   = r_busy;

endmodule

// File: tb/tb_div_seq.sv
// Scoreboard testbench for div_seq.
// Expected results are queued when an operation is driven.
// They are popped when ready_o rises.
module tb_div_seq;

  logic        clk;
  logic        rst;
  logic        signed_div_i;
  logic [31:0] opdata1_i;
  logic [31:0] opdata2_i;
  logic        start_i;
  logic        annul_i;
  logic [63:0] result_o;
  logic        ready_o;
  logic        busy_o;

  int n_cmp;
  int n_bad;
  logic [63:0] sb[$];

  div_seq dut (
    .clk          (clk),
    .rst          (rst),
    .signed_div_i (signed_div_i),
    .opdata1_i    (opdata1_i),
    .opdata2_i    (opdata2_i),
    .start_i      (start_i),
    .annul_i      (annul_i),
    .result_o     (result_o),
    .ready_o      (ready_o),
    .busy_o       (busy_o)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  // Reference: 64-bit arithmetic, truncating division, remainder takes dividend sign.
  function automatic logic [63:0] model(input bit s, input logic [31:0] a, input logic [31:0] b);
    longint la, lb, q, r;
    if (b == 32'd0) return 64'd0;
    if (s) begin
      la = longint'($signed(a));
      lb = longint'($signed(b));
    end else begin
      la = longint'({32'd0, a});
      lb = longint'({32'd0, b});
    end
    q = la / lb;
    r = la % lb;
    return {r[31:0], q[31:0]};
  endfunction

  task automatic test_reset();
    rst = 1'b1;
    #2;
    n_cmp++; if (ready_o !== 1'b0) begin n_bad++; $display("FAIL reset_ready got=%b want=0", ready_o); end
    n_cmp++; if (busy_o !== 1'b0) begin n_bad++; $display("FAIL reset_busy got=%b want=0", busy_o); end
    n_cmp++; if (result_o !== 64'd0) begin n_bad++; $display("FAIL reset_result got=%h want=0", result_o); end
    @(posedge clk); #1;
    rst = 1'b0;
  endtask

  // Full operation: accept, wait for ready, optionally hold in END, then release.
  task automatic test_divide(input bit s, input logic [31:0] a, input logic [31:0] b, input int hold);
    logic [63:0] exp;
    int lat, exp_lat;
    exp_lat = (b == 32'd0) ? 1 : 33;
    exp = 64'd0;
    signed_div_i = s; opdata1_i = a; opdata2_i = b; annul_i = 1'b0; start_i = 1'b1;
    sb.push_back(model(s, a, b));
    @(posedge clk); #1;
    opdata1_i = $urandom; opdata2_i = $urandom; signed_div_i = ~s;
    n_cmp++; if (busy_o !== 1'b1) begin n_bad++; $display("FAIL busy_after_accept got=%b want=1", busy_o); end
    lat = 0;
    while (ready_o !== 1'b1 && lat < 60) begin
      @(posedge clk); #1;
      lat++;
      if (lat < exp_lat) begin
        n_cmp++; if (busy_o !== 1'b1 || ready_o !== 1'b0) begin
          n_bad++; $display("FAIL busy_during lat=%0d busy=%b ready=%b want busy=1 ready=0", lat, busy_o, ready_o);
        end
      end
    end
    n_cmp++; if (lat != exp_lat) begin n_bad++; $display("FAIL latency got=%0d want=%0d", lat, exp_lat); end
    if (ready_o === 1'b1 && sb.size() > 0) begin
      exp = sb.pop_front();
      n_cmp++; if (result_o !== exp) begin n_bad++; $display("FAIL result a=%h b=%h s=%0d got=%h want=%h", a, b, s, result_o, exp); end
      n_cmp++; if (busy_o !== 1'b0) begin n_bad++; $display("FAIL busy_at_ready got=%b want=0", busy_o); end
    end
    for (int h = 0; h < hold; h++) begin
      @(posedge clk); #1;
      n_cmp++; if (ready_o !== 1'b1 || result_o !== exp || busy_o !== 1'b0) begin
        n_bad++; $display("FAIL end_hold cyc=%0d ready=%b busy=%b result=%h want ready=1 busy=0 result=%h", h, ready_o, busy_o, result_o, exp);
      end
    end
    start_i = 1'b0;
    @(posedge clk); #1;
    n_cmp++; if (ready_o !== 1'b0 || result_o !== 64'd0 || busy_o !== 1'b0) begin
      n_bad++; $display("FAIL release ready=%b busy=%b result=%h want 0/0/0", ready_o, busy_o, result_o);
    end
  endtask

  task automatic test_annul();
    signed_div_i = 1'b0; opdata1_i = 32'd50; opdata2_i = 32'd7; annul_i = 1'b0; start_i = 1'b1;
    sb.push_back(model(1'b0, 32'd50, 32'd7));
    @(posedge clk); #1;
    for (int k = 1; k <= 10; k++) begin
      @(posedge clk); #1;
      n_cmp++; if (ready_o !== 1'b0) begin n_bad++; $display("FAIL annul_early_ready k=%0d got=%b want=0", k, ready_o); end
    end
    annul_i = 1'b1;
    @(posedge clk); #1;
    annul_i = 1'b0;
    void'(sb.pop_back());
    n_cmp++; if (busy_o !== 1'b0 || ready_o !== 1'b0 || result_o !== 64'd0) begin
      n_bad++; $display("FAIL annul_free busy=%b ready=%b result=%h want 0/0/0", busy_o, ready_o, result_o);
    end
    test_divide(1'b0, 32'd9, 32'd3, 0);
  endtask

  task automatic test_async_reset();
    signed_div_i = 1'b1; opdata1_i = 32'h12345678; opdata2_i = 32'd3; annul_i = 1'b0; start_i = 1'b1;
    sb.push_back(model(1'b1, 32'h12345678, 32'd3));
    @(posedge clk); #1;
    for (int k = 1; k <= 20; k++) begin
      @(posedge clk); #1;
    end
    #2 rst = 1'b1;
    #1;
    n_cmp++; if (busy_o !== 1'b0 || ready_o !== 1'b0 || result_o !== 64'd0) begin
      n_bad++; $display("FAIL async_reset busy=%b ready=%b result=%h want 0/0/0", busy_o, ready_o, result_o);
    end
    void'(sb.pop_back());
    start_i = 1'b0;
    @(posedge clk); #1;
    rst = 1'b0;
    test_divide(1'b1, 32'h80000000, 32'hFFFFFFFF, 0);
  endtask

  task automatic test_start_with_annul();
    signed_div_i = 1'b0; opdata1_i = 32'd77; opdata2_i = 32'd5; start_i = 1'b1; annul_i = 1'b1;
    for (int k = 0; k < 3; k++) begin
      @(posedge clk); #1;
      n_cmp++; if (busy_o !== 1'b0 || ready_o !== 1'b0) begin
        n_bad++; $display("FAIL start_annul cyc=%0d busy=%b ready=%b want 0/0", k, busy_o, ready_o);
      end
    end
    start_i = 1'b0; annul_i = 1'b0;
    @(posedge clk); #1;
  endtask

  initial begin
    n_cmp = 0; n_bad = 0;
    signed_div_i = 1'b0; opdata1_i = 32'd0; opdata2_i = 32'd0;
    start_i = 1'b0; annul_i = 1'b0; rst = 1'b1;
    test_reset();
    test_divide(1'b0, 32'd100, 32'd7, 0);
    test_divide(1'b1, 32'hFFFFFFF9, 32'h00000002, 0);
    test_divide(1'b0, 32'hFFFFFFFF, 32'd1, 0);
    test_divide(1'b0, 32'd5, 32'd0, 0);
    test_divide(1'b1, 32'hFFFFFF9C, 32'd7, 0);
    test_divide(1'b1, 32'd100, 32'hFFFFFFF9, 0);
    test_divide(1'b0, 32'd3, 32'd10, 0);
    for (int i = 0; i < 6; i++) begin
      test_divide(i[0], $urandom, $urandom_range(1, 32'h0000FFFF) << (i * 3), 0);
    end
    test_annul();
    test_async_reset();
    test_start_with_annul();
    test_divide(1'b0, 32'd1000, 32'd33, 5);
    test_divide(1'b1, 32'd9, 32'd0, 3);
    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
    $finish;
  end

endmodule
